// File: rtl/ram8_arbiter.sv
// Two-port round-robin arbiter and sequencer for the RAM8 8x8 scratch RAM.
// Optional bus locking (LOCK0/LOCK1 ports, owner FSM) is built when RAM8_ARB_LOCK_EN is defined.
module ram8_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
`ifdef RAM8_ARB_LOCK_EN
  input  logic              LOCK0,
  input  logic              LOCK1,
`endif
  input  logic              REQ0,
  input  logic              WE0_IN,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] WDATA0,
  output logic              GNT0,
  output logic              RVALID0,
  output logic [DATA_W-1:0] RDATA0,
  input  logic              REQ1,
  input  logic              WE1_IN,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              GNT1,
  output logic              RVALID1,
  output logic [DATA_W-1:0] RDATA1,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_A,
  output logic [DATA_W-1:0] RAM_DI,
  input  logic [DATA_W-1:0] RAM_DO
);

  localparam int NPORT = 2;

  logic              req   [NPORT];
  logic              we    [NPORT];
  logic [ADDR_W-1:0] addr  [NPORT];
  logic [DATA_W-1:0] wdata [NPORT];

  logic [NPORT-1:0]  elig;
  logic [NPORT-1:0]  gnt;
  logic              last_reg;
  logic              mux_we;
  logic [ADDR_W-1:0] mux_a;
  logic [DATA_W-1:0] mux_di;

  assign req[0]   = REQ0;
  assign req[1]   = REQ1;
  assign we[0]    = WE0_IN;
  assign we[1]    = WE1_IN;
  assign addr[0]  = ADDR0;
  assign addr[1]  = ADDR1;
  assign wdata[0] = WDATA0;
  assign wdata[1] = WDATA1;

`ifdef RAM8_ARB_LOCK_EN
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  owner_t owner_reg;

  // A locked owner masks the other port even while the owner itself is idle.
  always_comb begin
    elig = {req[1], req[0]};
    case (owner_reg)
      OWN_P0:  elig[1] = 1'b0;
      OWN_P1:  elig[0] = 1'b0;
      default: elig = {req[1], req[0]};
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      owner_reg <= OWN_NONE;
    end else begin
      case (owner_reg)
        OWN_NONE: begin
          if (gnt[0] && LOCK0) begin
            owner_reg <= OWN_P0;
          end else if (gnt[1] && LOCK1) begin
            owner_reg <= OWN_P1;
          end
        end
        OWN_P0: begin
          if (!REQ0 || (gnt[0] && !LOCK0)) begin
            owner_reg <= OWN_NONE;
          end
        end
        OWN_P1: begin
          if (!REQ1 || (gnt[1] && !LOCK1)) begin
            owner_reg <= OWN_NONE;
          end
        end
        default: owner_reg <= OWN_NONE;
      endcase
    end
  end
`else
  assign elig = {req[1], req[0]};
`endif

  // On a tie the port that was not granted last wins; reset makes port 0 win first.
  always_comb begin
    gnt = '0;
    if (RST_N) begin
      if (elig == 2'b11) begin
        gnt = last_reg ? 2'b01 : 2'b10;
      end else begin
        gnt = elig;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_reg <= 1'b1;
    end else if (|gnt) begin
      last_reg <= gnt[1];
    end
  end

  always_comb begin
    mux_we = 1'b0;
    mux_a  = '0;
    mux_di = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (gnt[i]) begin
        mux_we = we[i];
        mux_a  = addr[i];
        mux_di = wdata[i];
      end
    end
  end

  assign RAM_EN = |gnt;
  assign RAM_WE = mux_we;
  assign RAM_A  = mux_a;
  assign RAM_DI = mux_di;
  assign GNT0   = gnt[0];
  assign GNT1   = gnt[1];

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_port
      logic              rvalid_reg;
      logic [DATA_W-1:0] rdata_reg;
      logic              rd_take;

      assign rd_take = gnt[gi] & ~we[gi];

      // Read data is held until this port's next read completes.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= rd_take;
          if (rd_take) begin
            rdata_reg <= RAM_DO;
          end
        end
      end
    end
  endgenerate

  assign RVALID0 = g_port[0].rvalid_reg;
  assign RDATA0  = g_port[0].rdata_reg;
  assign RVALID1 = g_port[1].rvalid_reg;
  assign RDATA1  = g_port[1].rdata_reg;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Self-checking bench for ram8_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of grants, memory contents and read returns.
module tb_ram8_arbiter;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_di, ram_do;
`ifdef RAM8_ARB_LOCK_EN
  logic          lock0 = 1'b0, lock1 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // RAM8 stand-in: combinational read, write on rising edge
  logic [DW-1:0] ram_array [8];
  assign ram_do = (ram_en && !ram_we) ? ram_array[ram_a] : '0;
  always @(posedge clk) if (ram_en && ram_we) ram_array[ram_a] <= ram_di;

  // reference model state
  logic [DW-1:0] m_mem [8];
  int            m_last;
  int            m_owner;
  logic [1:0]    m_rvalid;
  logic [DW-1:0] m_rdata [2];
  int            e_win;
  logic [1:0]    e_gnt;
  logic          e_en, e_we;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_di;

  always #5 clk = ~clk;

  ram8_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(clk), .RST_N(rst_n),
`ifdef RAM8_ARB_LOCK_EN
    .LOCK0(lock0), .LOCK1(lock1),
`endif
    .REQ0(req0), .WE0_IN(we0), .ADDR0(addr0), .WDATA0(wdata0),
    .GNT0(gnt0), .RVALID0(rvalid0), .RDATA0(rdata0),
    .REQ1(req1), .WE1_IN(we1), .ADDR1(addr1), .WDATA1(wdata1),
    .GNT1(gnt1), .RVALID1(rvalid1), .RDATA1(rdata1),
    .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_A(ram_a), .RAM_DI(ram_di), .RAM_DO(ram_do)
  );

  task automatic model_reset();
    m_last    = 1;
    m_owner   = -1;
    m_rvalid  = 2'b00;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    e_win     = -1;
  endtask

  // Winner for the current cycle from the round-robin and ownership rules.
  task automatic model_predict();
    logic [1:0] r;
    r = {req1, req0};
    if (m_owner == 0) r[1] = 1'b0;
    if (m_owner == 1) r[0] = 1'b0;
    if (!rst_n || r == 2'b00) e_win = -1;
    else if (r == 2'b11) e_win = 1 - m_last;
    else e_win = r[0] ? 0 : 1;
    e_gnt = 2'b00; e_en = 1'b0; e_we = 1'b0; e_a = '0; e_di = '0;
    if (e_win == 0) begin
      e_gnt = 2'b01; e_en = 1'b1; e_we = we0; e_a = addr0; e_di = wdata0;
    end else if (e_win == 1) begin
      e_gnt = 2'b10; e_en = 1'b1; e_we = we1; e_a = addr1; e_di = wdata1;
    end
  endtask

  // Apply the predicted transfer at the clock edge.
  task automatic model_commit();
    m_rvalid = 2'b00;
    if (e_win == 0) begin
      if (we0) m_mem[addr0] = wdata0;
      else begin m_rvalid[0] = 1'b1; m_rdata[0] = m_mem[addr0]; end
    end else if (e_win == 1) begin
      if (we1) m_mem[addr1] = wdata1;
      else begin m_rvalid[1] = 1'b1; m_rdata[1] = m_mem[addr1]; end
    end
    if (e_win >= 0) m_last = e_win;
`ifdef RAM8_ARB_LOCK_EN
    if (m_owner < 0) begin
      if (e_win == 0 && lock0) m_owner = 0;
      else if (e_win == 1 && lock1) m_owner = 1;
    end else if (m_owner == 0) begin
      if (!req0 || (e_win == 0 && !lock0)) m_owner = -1;
    end else begin
      if (!req1 || (e_win == 1 && !lock1)) m_owner = -1;
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 3'd5;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, ram_en, ram_we, rvalid0, rvalid1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000", {gnt0, gnt1, ram_en, ram_we, rvalid0, rvalid1});
    end
    checks++;
    if ({ram_a, ram_di, rdata0, rdata1} !== '0) begin
      errors++;
      $display("FAIL reset_data got a=%h di=%h rd0=%h rd1=%h want all 0", ram_a, ram_di, rdata0, rdata1);
    end
    req0 = 1'b0;
    rst_n = 1'b1;
    #1 model_predict();
    checks++;
    if ({gnt1, gnt0, ram_en} !== {e_gnt, e_en}) begin
      errors++;
      $display("FAIL reset_release_idle got %b want %b", {gnt1, gnt0, ram_en}, {e_gnt, e_en});
    end
    @(posedge clk); model_commit(); #1;
  endtask

  task automatic test_fill();
    for (int a = 0; a < 8; a++) begin
      req0 = 1'b1; we0 = 1'b1; addr0 = AW'(a); wdata0 = DW'($urandom);
      @(negedge clk); model_predict();
      checks++;
      if ({gnt1, gnt0, ram_en, ram_we, ram_a, ram_di} !== {2'b01, 1'b1, 1'b1, e_a, e_di}) begin
        errors++;
        $display("FAIL fill a=%0d got g=%b%b en=%b we=%b a=%h di=%h want g=01 en=1 we=1 a=%h di=%h",
                 a, gnt1, gnt0, ram_en, ram_we, ram_a, ram_di, e_a, e_di);
      end
      @(posedge clk); model_commit(); #1;
    end
    req0 = 1'b0;
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd3; wdata0 = 8'hA5;
    @(negedge clk); model_predict();
    checks++;
    if ({gnt0, gnt1, ram_en, ram_we, ram_a, ram_di} !== {4'b1011, 3'd3, 8'hA5}) begin
      errors++;
      $display("FAIL wr_issue got g0=%b g1=%b en=%b we=%b a=%h di=%h want 1 0 1 1 3 a5",
               gnt0, gnt1, ram_en, ram_we, ram_a, ram_di);
    end
    @(posedge clk); model_commit(); #1;
    we0 = 1'b0;
    @(negedge clk); model_predict();
    checks++;
    if ({gnt0, ram_en, ram_we, ram_a, rvalid0} !== {3'b110, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL rd_issue got g0=%b en=%b we=%b a=%h rv0=%b want 1 1 0 3 0",
               gnt0, ram_en, ram_we, ram_a, rvalid0);
    end
    @(posedge clk); model_commit(); #1;
    req0 = 1'b0;
    @(negedge clk); model_predict();
    checks++;
    if ({rvalid0, rdata0} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL raw_data got rv0=%b rd0=%h want 1 a5", rvalid0, rdata0);
    end
    @(posedge clk); model_commit(); #1;
    @(negedge clk); model_predict();
    checks++;
    if ({rvalid0, rdata0} !== {1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL rd_hold got rv0=%b rd0=%h want 0 a5", rvalid0, rdata0);
    end
    @(posedge clk); model_commit(); #1;
  endtask

  task automatic test_reset_midrun();
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd3;
    @(negedge clk); model_predict();
    @(posedge clk); model_commit(); #1;
    checks++;
    if ({rvalid0, rdata0} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL pre_reset_read got rv0=%b rd0=%h want 1 a5", rvalid0, rdata0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt0, ram_en, ram_we, rvalid0, rdata0, ram_a} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got g0=%b en=%b we=%b rv0=%b rd0=%h a=%h want all 0",
               gnt0, ram_en, ram_we, rvalid0, rdata0, ram_a);
    end
    model_reset();
    @(negedge clk); model_predict();
    checks++;
    if ({gnt1, gnt0, ram_en, rvalid0} !== {e_gnt, e_en, m_rvalid[0]}) begin
      errors++;
      $display("FAIL reset_held got %b want %b", {gnt1, gnt0, ram_en, rvalid0}, {e_gnt, e_en, m_rvalid[0]});
    end
    @(posedge clk); model_commit();
    @(negedge clk);
    req0 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alternate();
    logic [1:0] want_g [4];
    logic [1:0] want_v [5];
    want_g[0] = 2'b01; want_g[1] = 2'b10; want_g[2] = 2'b01; want_g[3] = 2'b10;
    want_v[0] = 2'b00; want_v[1] = 2'b01; want_v[2] = 2'b10; want_v[3] = 2'b01; want_v[4] = 2'b10;
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd2;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk); model_predict();
      if (i < 4) begin
        checks++;
        if ({gnt1, gnt0} !== want_g[i]) begin
          errors++;
          $display("FAIL alt_grant step %0d got %b want %b", i, {gnt1, gnt0}, want_g[i]);
        end
      end
      checks++;
      if ({rvalid1, rvalid0, rdata1, rdata0} !== {want_v[i], m_rdata[1], m_rdata[0]}) begin
        errors++;
        $display("FAIL alt_rvalid step %0d got v=%b d1=%h d0=%h want v=%b d1=%h d0=%h",
                 i, {rvalid1, rvalid0}, rdata1, rdata0, want_v[i], m_rdata[1], m_rdata[0]);
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  task automatic test_same_addr();
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd7; wdata0 = 8'h11;
    req1 = 1'b1; we1 = 1'b1; addr1 = 3'd7; wdata1 = 8'h22;
    @(negedge clk); model_predict();
    checks++;
    if ({gnt1, gnt0, ram_di} !== {2'b01, 8'h11}) begin
      errors++;
      $display("FAIL same_addr_first got g=%b di=%h want 01 11", {gnt1, gnt0}, ram_di);
    end
    @(posedge clk); model_commit(); #1;
    req0 = 1'b0;
    @(negedge clk); model_predict();
    checks++;
    if ({gnt1, gnt0, ram_di} !== {2'b10, 8'h22}) begin
      errors++;
      $display("FAIL same_addr_second got g=%b di=%h want 10 22", {gnt1, gnt0}, ram_di);
    end
    @(posedge clk); model_commit(); #1;
    req1 = 1'b0; req0 = 1'b1; we0 = 1'b0;
    @(negedge clk); model_predict();
    @(posedge clk); model_commit(); #1;
    req0 = 1'b0;
    @(negedge clk); model_predict();
    checks++;
    if ({rvalid0, rdata0} !== {1'b1, 8'h22}) begin
      errors++;
      $display("FAIL same_addr_read got rv0=%b rd0=%h want 1 22", rvalid0, rdata0);
    end
    @(posedge clk); model_commit(); #1;
  endtask

  task automatic test_lone_port1();
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd0;
    @(negedge clk); model_predict();
    checks++;
    if ({gnt1, gnt0, ram_en, ram_we, ram_a} !== {4'b1010, 3'd0}) begin
      errors++;
      $display("FAIL lone1_grant got g=%b en=%b we=%b a=%h want 10 1 0 0", {gnt1, gnt0}, ram_en, ram_we, ram_a);
    end
    @(posedge clk); model_commit(); #1;
    req1 = 1'b0;
    @(negedge clk); model_predict();
    checks++;
    if ({rvalid1, rvalid0, rdata1, rdata0} !== {2'b10, m_mem[0], 8'h22}) begin
      errors++;
      $display("FAIL lone1_return got v=%b d1=%h d0=%h want v=10 d1=%h d0=22",
               {rvalid1, rvalid0}, rdata1, rdata0, m_mem[0]);
    end
    @(posedge clk); model_commit(); #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      // a requester that lost arbitration keeps its request unchanged
      if (!(req0 && e_win != 0)) begin
        req0 = ($urandom_range(0, 99) < 60); we0 = 1'($urandom_range(0, 1));
        addr0 = AW'($urandom_range(0, 7)); wdata0 = DW'($urandom);
`ifdef RAM8_ARB_LOCK_EN
        lock0 = ($urandom_range(0, 3) == 0);
`endif
      end
      if (!(req1 && e_win != 1)) begin
        req1 = ($urandom_range(0, 99) < 60); we1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, 7)); wdata1 = DW'($urandom);
`ifdef RAM8_ARB_LOCK_EN
        lock1 = ($urandom_range(0, 3) == 0);
`endif
      end
      @(negedge clk); model_predict();
      checks++;
      if ({gnt1, gnt0, ram_en, ram_we} !== {e_gnt, e_en, e_we}) begin
        errors++;
        $display("FAIL rand_ctrl cyc %0d got %b want %b", c, {gnt1, gnt0, ram_en, ram_we}, {e_gnt, e_en, e_we});
      end
      checks++;
      if ({ram_a, ram_di} !== {e_a, e_di}) begin
        errors++;
        $display("FAIL rand_bus cyc %0d got a=%h di=%h want a=%h di=%h", c, ram_a, ram_di, e_a, e_di);
      end
      checks++;
      if ({rvalid1, rvalid0, rdata1, rdata0} !== {m_rvalid, m_rdata[1], m_rdata[0]}) begin
        errors++;
        $display("FAIL rand_read cyc %0d got v=%b d1=%h d0=%h want v=%b d1=%h d0=%h",
                 c, {rvalid1, rvalid0}, rdata1, rdata0, m_rvalid, m_rdata[1], m_rdata[0]);
      end
      @(posedge clk); model_commit(); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
`ifdef RAM8_ARB_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif
    // let any remaining ownership lapse
    @(negedge clk); model_predict();
    @(posedge clk); model_commit(); #1;
  endtask

`ifdef RAM8_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] want_g;
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd4; lock0 = 1'b0;
    @(negedge clk); model_predict();
    checks++;
    if ({gnt1, gnt0} !== 2'b01) begin
      errors++;
      $display("FAIL lock_setup got %b want 01", {gnt1, gnt0});
    end
    @(posedge clk); model_commit(); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 3'd5; lock1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) lock1 = 1'b0;
      if (i == 4) req1 = 1'b0;
      wdata1 = DW'($urandom);
      want_g = (i < 4) ? 2'b10 : 2'b01;
      @(negedge clk); model_predict();
      checks++;
      if ({gnt1, gnt0} !== want_g) begin
        errors++;
        $display("FAIL lock_grant step %0d got %b want %b", i, {gnt1, gnt0}, want_g);
      end
      @(posedge clk); model_commit(); #1;
    end
    req0 = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    model_reset();
    test_reset();
    test_fill();
    test_write_read();
    test_reset_midrun();
    test_alternate();
    test_same_addr();
    test_lone_port1();
    test_random();
`ifdef RAM8_ARB_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
